mat_loader: RTL and testbench
=============================

MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 Parameter: rsize, default 2, number of matrix rows.
REQ-002 Parameter: csize, default 3, number of matrix columns.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_data  input  32  streamed matrix element.
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_ready  output  1  loader accepts a beat this cycle.
REQ-008 Port: abort  input  1  discard partial load or held pair, restart at matrix A.
REQ-009 Port: mat_a  output  32 x [rsize][csize]  assembled first operand (adder in1).
REQ-010 Port: mat_b  output  32 x [rsize][csize]  assembled second operand (adder in2).
REQ-011 Port: mat_valid  output  1  mat_a/mat_b complete and stable.
REQ-012 Port: mat_ack  input  1  consumer has taken the held pair.

Function
REQ-013 FSM states SHALL be LOAD_A, LOAD_B, HOLD; in_ready = 1 in LOAD_A/LOAD_B, 0 in HOLD, 0 while rst_n = 0.
REQ-014 Beat accepted iff in_valid & in_ready & !abort on a rising edge; no other beats change any state.
REQ-015 Element order row-major: beat k of a matrix writes [k / csize][k % csize]; row/col counters, col wraps at csize-1 and increments row.
REQ-016 LOAD_A: accepted beat writes mat_a at current index; beat at [rsize-1][csize-1] -> LOAD_B, counters to 0.
REQ-017 LOAD_B: accepted beat writes mat_b; beat at [rsize-1][csize-1] -> HOLD, counters to 0.
REQ-018 mat_valid SHALL be registered, = 1 exactly when state = HOLD; first asserted the cycle after the final mat_b beat.
REQ-019 Latency: full pair of 2*rsize*csize beats with in_valid continuously 1 -> mat_valid high on cycle 2*rsize*csize+1 after first accept edge.
REQ-020 In_valid gaps SHALL stall loading without losing position.
REQ-021 HOLD: mat_a, mat_b unchanged every cycle; in_valid ignored.
REQ-022 HOLD & mat_ack -> LOAD_A next cycle, mat_valid 0; mat_a/mat_b keep values until overwritten.
REQ-023 mat_ack outside HOLD SHALL be ignored.
REQ-024 abort in any state -> LOAD_A next cycle, counters 0, mat_valid 0; beat presented same cycle discarded; matrix contents not cleared.
REQ-025 abort and mat_ack same cycle -> handled as abort (identical result).
REQ-026 Element writes SHALL touch only the addressed 32-bit entry; no arithmetic on data.

Reset
REQ-027 rst_n = 0 at a rising edge SHALL force LOAD_A, counters 0, mat_valid 0, all mat_a/mat_b entries 0.
REQ-028 Reset mid-load or in HOLD SHALL discard progress; first beat after release writes mat_a[0][0].
REQ-029 in_ready = 0 and mat_ack/abort ignored while rst_n = 0.

Verification (rsize=2, csize=3)
REQ-030 Reset, then 12 back-to-back beats 1..12 -> mat_a[0][0]=1, mat_a[0][2]=3, mat_a[1][2]=6, mat_b[0][0]=7, mat_b[1][2]=12; mat_valid rises cycle after beat 12, in_ready falls same edge.
REQ-031 In HOLD drive in_valid=1, data 0xDEAD for 5 cycles -> no change to mat_a/mat_b, mat_valid stays 1; then mat_ack -> mat_valid 0, in_ready 1 next cycle.
REQ-032 Beats 1..12 with in_valid toggling every other cycle -> same final contents as REQ-030, mat_valid after 12th accepted beat.
REQ-033 4 beats, abort (in_valid=1, data 99 same cycle), then 12 beats 101..112 -> mat_a[0][0]=101, mat_b[1][2]=112, 99 never stored.
REQ-034 8 beats, rst_n=0 one cycle -> all entries 0, mat_valid 0; next 12 beats fill from mat_a[0][0].
REQ-035 Abort and mat_ack together in HOLD -> LOAD_A, mat_valid 0, contents retained.

Source files
------------

// File: rtl/mat_loader_if.sv
// ---------------------------------------------------------------------------
// mat_loader_if : element stream in, assembled matrix pair out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mat_loader_if #(
   parameter int rsize = 2,
   parameter int csize = 3
);
   logic [31:0]                         in_data;
   logic                                in_valid;
   logic                                in_ready;
   logic                                abort;
   logic [rsize-1:0][csize-1:0][31:0]   mat_a;
   logic [rsize-1:0][csize-1:0][31:0]   mat_b;
   logic                                mat_valid;
   logic                                mat_ack;

   modport master (
      output in_data, in_valid, abort, mat_ack,
      input  in_ready, mat_a, mat_b, mat_valid
   );

   modport slave (
      input  in_data, in_valid, abort, mat_ack,
      output in_ready, mat_a, mat_b, mat_valid
   );
endinterface

`default_nettype wire

// File: rtl/mat_loader.sv
// ---------------------------------------------------------------------------
// mat_loader : assembles two row-major streamed matrices and holds the pair
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mat_loader #(
   parameter int rsize = 2,
   parameter int csize = 3
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   mat_loader_if.slave bus
);

   localparam int RW = (rsize > 1) ? $clog2(rsize) : 1;
   localparam int CW = (csize > 1) ? $clog2(csize) : 1;
   localparam logic [RW-1:0] c_row_last = RW'(rsize - 1);
   localparam logic [CW-1:0] c_col_last = CW'(csize - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [RW-1:0]                       row_q, row_d;
   logic [CW-1:0]                       col_q, col_d;
   logic                                mat_valid_q, mat_valid_d;
   logic [rsize-1:0][csize-1:0][31:0]   mat_a_q, mat_b_q;
   logic                                wr_a, wr_b;
   logic                                accept;
   logic                                last_elem;

   assign bus.in_ready  = rst_n && (state_q != HOLD);
   assign bus.mat_a     = mat_a_q;
   assign bus.mat_b     = mat_b_q;
   assign bus.mat_valid = mat_valid_q;

   assign accept    = bus.in_valid && bus.in_ready && !bus.abort;
   assign last_elem = (row_q == c_row_last) && (col_q == c_col_last);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      if (bus.abort) begin
         // abort wins over mat_ack and discards the beat on the bus
         state_d = LOAD_A;
         row_d   = '0;
         col_d   = '0;
      end else begin
         case (state_q)
            LOAD_A, LOAD_B: begin
               if (accept) begin
                  wr_a = (state_q == LOAD_A);
                  wr_b = (state_q == LOAD_B);
                  if (last_elem) begin
                     state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
                     row_d   = '0;
                     col_d   = '0;
                  end else if (col_q == c_col_last) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.mat_ack) begin
                  state_d = LOAD_A;
               end
            end
            default: begin
               state_d = LOAD_A;
               row_d   = '0;
               col_d   = '0;
            end
         endcase
      end
      mat_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= LOAD_A;
         row_q       <= '0;
         col_q       <= '0;
         mat_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         mat_valid_q <= mat_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mat_a_q <= '0;
         mat_b_q <= '0;
      end else begin
         if (wr_a) begin
            mat_a_q[row_q][col_q] <= bus.in_data;
         end
         if (wr_b) begin
            mat_b_q[row_q][col_q] <= bus.in_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mat_loader.sv
// ---------------------------------------------------------------------------
// tb_mat_loader : directed self-checking bench for mat_loader (2x3)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mat_loader;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   mat_loader_if #(.rsize(2), .csize(3)) bus ();

   mat_loader #(.rsize(2), .csize(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // a holds base+1..base+6, b holds base+7..base+12, row-major
   task automatic chk_all(input string tag, input int base);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_a%0d%0d", tag, r, c), bus.mat_a[r][c], 32'(base + r*3 + c + 1));
            chk($sformatf("%s_b%0d%0d", tag, r, c), bus.mat_b[r][c], 32'(base + r*3 + c + 7));
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_a%0d%0d", tag, r, c), bus.mat_a[r][c], 32'd0);
            chk($sformatf("%s_b%0d%0d", tag, r, c), bus.mat_b[r][c], 32'd0);
         end
      end
   endtask

   initial begin
      int k;
      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      bus.mat_ack  = 1'b0;

      // reset, with ack/abort/valid wiggling to show they are ignored
      tick();
      bus.mat_ack  = 1'b1;
      bus.abort    = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_valid", 32'(bus.mat_valid), 32'd0);
      chk_zero("rst");
      bus.mat_ack  = 1'b0;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      tick();
      chk("rel_ready", 32'(bus.in_ready), 32'd1);

      // back-to-back 1..12; ack asserted during load must be ignored
      bus.mat_ack = 1'b1;
      for (int i = 1; i <= 11; i++) beat(32'(i));
      bus.mat_ack = 1'b0;
      chk("b2b_v11", 32'(bus.mat_valid), 32'd0);
      chk("b2b_r11", 32'(bus.in_ready), 32'd1);
      beat(32'd12);
      chk("b2b_valid", 32'(bus.mat_valid), 32'd1);
      chk("b2b_ready", 32'(bus.in_ready), 32'd0);
      chk_all("b2b", 0);

      // HOLD ignores in_valid
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold_v%0d", i), 32'(bus.mat_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      chk_all("hold", 0);
      bus.mat_ack = 1'b1;
      tick();
      bus.mat_ack = 1'b0;
      chk("ack_valid", 32'(bus.mat_valid), 32'd0);
      chk("ack_ready", 32'(bus.in_ready), 32'd1);
      chk_all("ack_keep", 0);

      // abort mid-load discards the beat presented with it
      for (int i = 51; i <= 54; i++) beat(32'(i));
      bus.abort    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd99;
      tick();
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_valid", 32'(bus.mat_valid), 32'd0);
      chk("abort_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 101; i <= 112; i++) beat(32'(i));
      chk("abort_fill_v", 32'(bus.mat_valid), 32'd1);
      chk_all("abort", 100);
      bus.mat_ack = 1'b1;
      tick();
      bus.mat_ack = 1'b0;

      // in_valid toggling: gaps stall without losing position
      k = 1;
      while (k <= 12) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'(k);
         tick();
         k++;
         bus.in_valid = 1'b0;
         bus.in_data  = 32'hBAD0;
         if (k == 12) chk("gap_v11", 32'(bus.mat_valid), 32'd0);
         if (k <= 12) tick();
      end
      chk("gap_valid", 32'(bus.mat_valid), 32'd1);
      chk_all("gap", 0);
      bus.mat_ack = 1'b1;
      tick();
      bus.mat_ack = 1'b0;

      // reset mid-load clears everything and restarts at a[0][0]
      for (int i = 201; i <= 208; i++) beat(32'(i));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_valid", 32'(bus.mat_valid), 32'd0);
      chk_zero("mrst");
      for (int i = 301; i <= 311; i++) beat(32'(i));
      chk("mrst_v11", 32'(bus.mat_valid), 32'd0);
      beat(32'd312);
      chk("mrst_fill_v", 32'(bus.mat_valid), 32'd1);
      chk_all("mrst", 300);

      // abort together with ack in HOLD behaves as abort, contents kept
      bus.abort   = 1'b1;
      bus.mat_ack = 1'b1;
      tick();
      bus.abort   = 1'b0;
      bus.mat_ack = 1'b0;
      chk("aa_valid", 32'(bus.mat_valid), 32'd0);
      chk("aa_ready", 32'(bus.in_ready), 32'd1);
      chk_all("aa", 300);
      beat(32'd77);
      chk("aa_restart", bus.mat_a[0][0], 32'd77);
      chk("aa_keep_b", bus.mat_b[0][0], 32'd307);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
